// File: rtl/uart_tx_engine.sv
// uart_tx_engine
//   Transmit sequencer for the UART. A byte accepted on the load strobe is
//   framed as start, 7 or 8 data bits (LSB first), an optional parity bit and
//   stop fill, for NBITS bit-times in total. The engine times each bit-time
//   with its own divisor counter (btu) and serialises the frame onto tx.
//
// Ports
//   clk       in   1   system clock, all state on the rising edge
//   rst       in   1   asynchronous, active-high reset
//   load      in   1   one-cycle strobe, starts a frame when tx_rdy=1
//   out_port  in   8   data byte, sampled only on an accepted load
//   eight     in   1   1 = 8 data bits, 0 = 7 data bits
//   pen       in   1   parity enable
//   ohel      in   1   parity sense, 0 = even, 1 = odd
//   k         in   KW  clocks per bit-time (0 behaves as 1)
//   tx        out  1   serial line, idle high
//   tx_rdy    out  1   1 = idle and able to accept load
//   tx_done   out  1   one-cycle pulse when the last bit-time ends
module uart_tx_engine #(
    parameter int KW    = 20,
    parameter int NBITS = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [7:0]    out_port,
    input  logic          eight,
    input  logic          pen,
    input  logic          ohel,
    input  logic [KW-1:0] k,
    output logic          tx,
    output logic          tx_rdy,
    output logic          tx_done
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t            state_q, state_d;
    logic              doit;
    logic [KW-1:0]     kk;
    logic [KW-1:0]     btcnt_q;
    logic [3:0]        bcnt_q;
    logic [NBITS-1:0]  shift_q;
    logic              btu;
    logic              accept;
    logic              last;

    function automatic logic parity_bit(input logic [7:0] d, input logic e,
                                        input logic odd);
        parity_bit = (e ? ^d : ^d[6:0]) ^ odd;
    endfunction

    // Frame image with bit 0 (start) in the LSB; everything above the data
    // and optional parity stays 1 so it reads as stop fill.
    function automatic logic [NBITS-1:0] build_frame(input logic [7:0] d,
                                                     input logic e,
                                                     input logic p,
                                                     input logic odd);
        logic [NBITS-1:0] fr;
        fr    = '1;
        fr[0] = 1'b0;
        if (e) begin
            fr[8:1] = d;
            if (p) fr[9] = parity_bit(d, 1'b1, odd);
        end else begin
            fr[7:1] = d[6:0];
            if (p) fr[8] = parity_bit(d, 1'b0, odd);
        end
        build_frame = fr;
    endfunction

    assign doit   = (state_q == SEND);
    assign tx_rdy = (state_q == IDLE);
    assign kk     = (k == '0) ? KW'(1) : k;
    // ">=" rather than "==" so a k lowered mid-bit below the running count
    // ends the bit at the next compare instead of wrapping the whole counter.
    assign btu    = doit && (btcnt_q >= (kk - KW'(1)));
    assign accept = load && tx_rdy;
    assign last   = btu && (bcnt_q == 4'(NBITS - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = SEND;
            SEND: if (last)   state_d = IDLE;
            default:          state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // tx is a registered copy of the shift register LSB, so the line follows
    // the frame one clock after each load or shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '1;
            btcnt_q <= '0;
            bcnt_q  <= '0;
            tx      <= 1'b1;
            tx_done <= 1'b0;
        end else begin
            tx      <= shift_q[0];
            tx_done <= last;

            if (!doit || btu) btcnt_q <= '0;
            else              btcnt_q <= btcnt_q + KW'(1);

            if (last)     bcnt_q <= '0;
            else if (btu) bcnt_q <= bcnt_q + 4'd1;

            if (accept)   shift_q <= build_frame(out_port, eight, pen, ohel);
            else if (btu) shift_q <= {1'b1, shift_q[NBITS-1:1]};
        end
    end

endmodule

// File: tb/tb_uart_tx_engine.sv
module tb_uart_tx_engine;

    localparam int KW = 20;

    logic          clk = 1'b0;
    logic          rst;
    logic          load;
    logic [7:0]    out_port;
    logic          eight;
    logic          pen;
    logic          ohel;
    logic [KW-1:0] k;
    logic          tx;
    logic          tx_rdy;
    logic          tx_done;

    int   n_asrt = 0;
    int   n_fail = 0;
    logic exp_q[$];

    uart_tx_engine #(.KW(KW), .NBITS(11)) dut (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .out_port(out_port),
        .eight   (eight),
        .pen     (pen),
        .ohel    (ohel),
        .k       (k),
        .tx      (tx),
        .tx_rdy  (tx_rdy),
        .tx_done (tx_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    // Independent model of the line sequence: start, data LSB first,
    // optional parity, then 1s up to 11 bit-times.
    task automatic push_frame(input logic [7:0] d, input logic e,
                              input logic p, input logic o);
        int   nd;
        int   ones;
        logic b[11];
        nd   = e ? 8 : 7;
        ones = 0;
        for (int i = 0; i < 11; i++) b[i] = 1'b1;
        b[0] = 1'b0;
        for (int i = 0; i < nd; i++) begin
            b[i+1] = d[i];
            if (d[i]) ones++;
        end
        if (p) b[nd+1] = ((ones % 2) == 1) ^ o;
        for (int i = 0; i < 11; i++) exp_q.push_back(b[i]);
    endtask

    // Called at a falling edge; returns at a falling edge one clock after
    // tx_done, so consecutive calls present their load back-to-back.
    task automatic run_frame(input string nm, input logic [7:0] d,
                             input logic e, input logic p, input logic o,
                             input logic [KW-1:0] kv, input int intr_t,
                             input logic [7:0] intr_d, input int abort_t);
        int   kk;
        int   t;
        logic eb;
        kk = (kv == 0) ? 1 : int'(kv);
        k = kv; out_port = d; eight = e; pen = p; ohel = o;
        load = 1'b1;
        push_frame(d, e, p, o);
        @(negedge clk);
        load = 1'b0;
        chk({nm, " rdy_fall"}, tx_rdy, 1'b0);
        chk({nm, " tx_pre"}, tx, 1'b1);
        eb = 1'b1;
        for (int i = 0; i < 11; i++) begin
            for (int j = 0; j < kk; j++) begin
                @(negedge clk);
                t = 1 + i * kk + j;
                if (j == 0) eb = exp_q.pop_front();
                chk($sformatf("%s tx t%0d", nm, t), tx, eb);
                chk($sformatf("%s rdy t%0d", nm, t), tx_rdy, t == 11 * kk);
                chk($sformatf("%s done t%0d", nm, t), tx_done, t == 11 * kk);
                if (t == abort_t) begin
                    rst = 1'b1;
                    #1;
                    chk({nm, " abort_tx"}, tx, 1'b1);
                    chk({nm, " abort_rdy"}, tx_rdy, 1'b1);
                    chk({nm, " abort_done"}, tx_done, 1'b0);
                    @(negedge clk);
                    rst = 1'b0;
                    exp_q.delete();
                    return;
                end
                if (t == 1) begin
                    out_port = ~d; eight = ~e; pen = ~p; ohel = ~o;
                end
                if (t == intr_t) begin
                    load = 1'b1; out_port = intr_d;
                end else if (t == intr_t + 1) begin
                    load = 1'b0;
                end
            end
        end
        @(negedge clk);
        load = 1'b0;
        chk({nm, " tx_idle"}, tx, 1'b1);
        chk({nm, " rdy_idle"}, tx_rdy, 1'b1);
        chk({nm, " done_clr"}, tx_done, 1'b0);
        chk({nm, " q_empty"}, exp_q.size() == 0, 1'b1);
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; out_port = 8'h00;
        eight = 1'b1; pen = 1'b0; ohel = 1'b0; k = KW'(4);
        repeat (3) @(negedge clk);
        chk("reset tx", tx, 1'b1);
        chk("reset rdy", tx_rdy, 1'b1);
        chk("reset done", tx_done, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset tx", tx, 1'b1);

        // 8N, k=4; a load held on the edge where tx_rdy rises must be ignored
        run_frame("t1_55", 8'h55, 1'b1, 1'b0, 1'b0, KW'(4), 43, 8'h33, -1);
        // back-to-back: 8 data + even parity
        run_frame("t2_07", 8'h07, 1'b1, 1'b1, 1'b0, KW'(2), -1, 8'h00, -1);
        // 7 data + odd parity, bit 7 of the byte never sent
        run_frame("t3_ff", 8'hFF, 1'b0, 1'b1, 1'b1, KW'(2), -1, 8'h00, -1);
        // load while busy is dropped
        run_frame("t4_a5", 8'hA5, 1'b1, 1'b0, 1'b0, KW'(3), 10, 8'h00, -1);
        // k=0 behaves as one clock per bit
        run_frame("t5_01", 8'h01, 1'b1, 1'b0, 1'b0, KW'(0), -1, 8'h00, -1);
        // reset asserted during bit 5, then a clean frame
        run_frame("t6_ab", 8'h3C, 1'b1, 1'b1, 1'b1, KW'(2), -1, 8'h00, 11);
        run_frame("t6_c3", 8'hC3, 1'b1, 1'b1, 1'b0, KW'(2), -1, 8'h00, -1);
        // 7 data, no parity
        run_frame("t7_2a", 8'h2A, 1'b0, 1'b0, 1'b0, KW'(3), -1, 8'h00, -1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asrt, n_fail);
        $finish;
    end

endmodule
